// File: rtl/prog_clock_divider_if.sv
// Configuration write port of prog_clock_divider: ready/valid transfer of a
// new divide value into one channel's shadow register.
interface prog_clock_divider_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 32
);
  logic             cfg_valid;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel 50%-duty programmable clock divider with glitch-free reload at
// terminal count. Define CLKDIV_TICK_EN to add a per-channel rising-edge tick output.
module prog_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 25000000,
  parameter int CH_W        = 2
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   en,
  prog_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0]   clkout
`ifdef CLKDIV_TICK_EN
  ,
  output logic [NUM_CH-1:0]   tick
`endif
);

  localparam int CH_SLOTS = 1 << CH_W;

  logic [NUM_CH-1:0]   pending_vec;
  logic [CH_SLOTS-1:0] slot_live;
  logic [CH_SLOTS-1:0] slot_pending;
  logic                cfg_fire;

  // Pad per-channel state out to every cfg_ch code so out-of-range codes read as not ready.
  generate
    for (genvar gi = 0; gi < CH_SLOTS; gi++) begin : slot_g
      if (gi < NUM_CH) begin : live_g
        assign slot_live[gi]    = 1'b1;
        assign slot_pending[gi] = pending_vec[gi];
      end else begin : dead_g
        assign slot_live[gi]    = 1'b0;
        assign slot_pending[gi] = 1'b0;
      end
    end
  endgenerate

  assign cfg.cfg_ready = slot_live[cfg.cfg_ch] && !slot_pending[cfg.cfg_ch];
  assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : ch_g
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] div_act_q, div_act_d;
      logic [CNT_W-1:0] shadow_q, shadow_d;
      logic             clk_q, clk_d;
      logic             pending_q, pending_d;
      logic             tc;
      logic             wr_sel;
`ifdef CLKDIV_TICK_EN
      logic             tick_q, tick_d;
`endif

      assign wr_sel = cfg_fire && (cfg.cfg_ch == CH_W'(gi));

      always_comb begin
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        shadow_d  = shadow_q;
        clk_d     = clk_q;
        pending_d = pending_q;
        tc        = (cnt_q >= div_act_q);
`ifdef CLKDIV_TICK_EN
        tick_d    = 1'b0;
`endif
        if (!en[gi]) begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (pending_q) begin
            div_act_d = shadow_q;
            pending_d = 1'b0;
          end
        end else if (tc) begin
          cnt_d = '0;
          clk_d = !clk_q;
`ifdef CLKDIV_TICK_EN
          tick_d = !clk_q;
`endif
          if (pending_q) begin
            div_act_d = shadow_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // Writes are only accepted while nothing is pending, so this never races an apply.
        if (wr_sel) begin
          shadow_d  = cfg.cfg_div;
          pending_d = 1'b1;
        end
      end

      always_ff @(posedge clkin) begin
        if (reset) begin
          cnt_q     <= '0;
          div_act_q <= CNT_W'(DEFAULT_DIV);
          shadow_q  <= '0;
          clk_q     <= 1'b0;
          pending_q <= 1'b0;
`ifdef CLKDIV_TICK_EN
          tick_q    <= 1'b0;
`endif
        end else begin
          cnt_q     <= cnt_d;
          div_act_q <= div_act_d;
          shadow_q  <= shadow_d;
          clk_q     <= clk_d;
          pending_q <= pending_d;
`ifdef CLKDIV_TICK_EN
          tick_q    <= tick_d;
`endif
        end
      end

      assign clkout[gi]      = clk_q;
      assign pending_vec[gi] = pending_q;
`ifdef CLKDIV_TICK_EN
      assign tick[gi]        = tick_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider (NUM_CH=3, CNT_W=8, DEFAULT_DIV=3);
// tick checks are compiled in when CLKDIV_TICK_EN is defined.
module tb_prog_clock_divider;

  logic       clkin = 1'b0;
  logic       reset;
  logic [2:0] en;
  logic [2:0] clkout;
`ifdef CLKDIV_TICK_EN
  logic [2:0] tick;
`endif

  int checks   = 0;
  int failures = 0;

  prog_clock_divider_if #(.CH_W(2), .CNT_W(8)) cfg_if ();

  prog_clock_divider #(
    .NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(3), .CH_W(2)
  ) dut (
    .clkin (clkin),
    .reset (reset),
    .en    (en),
    .cfg   (cfg_if),
    .clkout(clkout)
`ifdef CLKDIV_TICK_EN
    ,
    .tick  (tick)
`endif
  );

  always #5 clkin = ~clkin;

  // Expected clkout vectors {ch2,ch1,ch0}, one per cycle of each window.
  localparam logic [2:0] EXP1 [12] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001,
                                       3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
  localparam logic [2:0] EXP2 [8]  = '{3'b001, 3'b001, 3'b001, 3'b000,
                                       3'b001, 3'b000, 3'b001, 3'b000};
  localparam logic       RDY2 [8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [2:0] EXP3 [8]  = '{3'b001, 3'b010, 3'b011, 3'b000,
                                       3'b001, 3'b010, 3'b011, 3'b000};
  localparam logic [2:0] EXP5 [12] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111,
                                       3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111};
  localparam logic [2:0] TCK5 [12] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000,
                                       3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset            = 1'b1;
    en               = 3'b000;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_div   = 8'd0;
    repeat (2) @(negedge clkin);
    chk("reset_clkout", 32'(clkout), 32'h0);
    chk("reset_ready0", 32'(cfg_if.cfg_ready), 32'h1);
`ifdef CLKDIV_TICK_EN
    chk("reset_tick", 32'(tick), 32'h0);
`endif

    // 1: default divide on ch0 only
    reset = 1'b0;
    en    = 3'b001;
    for (int k = 0; k < 12; k++) begin
      @(negedge clkin);
      chk($sformatf("s1_clkout_c%0d", k + 1), 32'(clkout), 32'(EXP1[k]));
    end

    // 2: reload ch0 to 0 while running
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_div   = 8'd0;
    #1 chk("s2_ready_pre", 32'(cfg_if.cfg_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clkin);
      if (k == 0) cfg_if.cfg_valid = 1'b0;
      #1;
      chk($sformatf("s2_clkout_c%0d", k + 13), 32'(clkout), 32'(EXP2[k]));
      chk($sformatf("s2_ready_c%0d", k + 13), 32'(cfg_if.cfg_ready), 32'(RDY2[k]));
    end

    // 3: ch1 write while disabled, second write while pending is dropped
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd1;
    cfg_if.cfg_div   = 8'd1;
    #1 chk("s3_ready_first", 32'(cfg_if.cfg_ready), 32'h1);
    @(negedge clkin);
    cfg_if.cfg_div = 8'd2;
    #1 chk("s3_ready_second", 32'(cfg_if.cfg_ready), 32'h0);
    chk("s3_clkout_c21", 32'(clkout), 32'h1);
    @(negedge clkin);
    cfg_if.cfg_valid = 1'b0;
    #1 chk("s3_ready_applied", 32'(cfg_if.cfg_ready), 32'h1);
    chk("s3_clkout_c22", 32'(clkout), 32'h0);
    en = 3'b011;
    for (int k = 0; k < 8; k++) begin
      @(negedge clkin);
      chk($sformatf("s3_clkout_c%0d", k + 23), 32'(clkout), 32'(EXP3[k]));
    end

    // 4: out-of-range channel is never ready and changes nothing
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd3;
    cfg_if.cfg_div   = 8'd5;
    #1 chk("s4_ready_ch3", 32'(cfg_if.cfg_ready), 32'h0);
    @(negedge clkin);
    cfg_if.cfg_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cfg_if.cfg_ch = 2'(c);
      #1 chk($sformatf("s4_ready_ch%0d", c), 32'(cfg_if.cfg_ready), 32'h1);
    end
    chk("s4_clkout_c31", 32'(clkout), 32'h1);

    // 5: same-edge write/terminal count on ch0, then reset with a write pending
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_div   = 8'd5;
    @(negedge clkin);
    cfg_if.cfg_valid = 1'b0;
    #1 chk("s5_ready_pending", 32'(cfg_if.cfg_ready), 32'h0);
    chk("s5_clkout_c32", 32'(clkout), 32'h2);
    @(negedge clkin);
    chk("s5_clkout_c33", 32'(clkout), 32'h3);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 8'd7;
    #1 chk("s5_ready_applied", 32'(cfg_if.cfg_ready), 32'h1);
    @(negedge clkin);
    cfg_if.cfg_valid = 1'b0;
    #1 chk("s5_ready_pending2", 32'(cfg_if.cfg_ready), 32'h0);
    chk("s5_clkout_c34", 32'(clkout), 32'h1);
    reset = 1'b1;
    @(negedge clkin);
    chk("s5_clkout_reset", 32'(clkout), 32'h0);
    #1 chk("s5_ready_reset", 32'(cfg_if.cfg_ready), 32'h1);
`ifdef CLKDIV_TICK_EN
    chk("s5_tick_reset", 32'(tick), 32'h0);
`endif
    reset = 1'b0;
    en    = 3'b111;

    // 6: all channels back at the default divide; ticks mark rising edges
    for (int k = 0; k < 12; k++) begin
      @(negedge clkin);
      chk($sformatf("s6_clkout_c%0d", k + 36), 32'(clkout), 32'(EXP5[k]));
`ifdef CLKDIV_TICK_EN
      chk($sformatf("s6_tick_c%0d", k + 36), 32'(tick), 32'(TCK5[k]));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
Multi-channel programmable clock divider; the parametrised successor of the fixed single-output divider. Each of NUM_CH channels produces a 50%-duty divided clock from clkin. Each channel has its own divide value, reloadable at run time through a ready/valid config port. New values take effect glitch-free at the channel's next terminal count. Sits at the top level, feeding display-scan, debounce and blink logic that currently use fixed dividers.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 32, counter and divide-value width in bits
DEFAULT_DIV, 25000000, divide value loaded into every channel at reset (must fit CNT_W)
CH_W, 2, width of cfg_ch; must satisfy 2**CH_W >= NUM_CH

Ports:
clkin  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
en  input  NUM_CH  per-channel run enable
cfg_valid  input  1  config write request
cfg_ch  input  CH_W  target channel of config write
cfg_div  input  CNT_W  new divide value
cfg_ready  output  1  config write can be accepted (combinational)
clkout  output  NUM_CH  divided clocks, registered

Behaviour:
- Reset (sampled on clkin edge) sets, per channel: cnt=0, clkout=0, div_act=DEFAULT_DIV, pending flag=0, shadow=0. Overrides all other activity, including mid-period and with a write pending.
- Counting, channel i with en[i]=1:
  - if cnt >= div_act: cnt<=0 and clkout[i] toggles (terminal count);
  - else cnt<=cnt+1.
  - Half-period = div_act+1 cycles; full period = 2*(div_act+1).
  - div_act=0 gives clkin/2.
  - The >= compare makes a reload below the current cnt wrap on the next cycle. No overflow path.
- Disable: en[i]=0 forces cnt<=0 and clkout[i]<=0 on the next edge. Counting resumes from 0 when en rises. The first rising edge of clkout[i] comes div_act+1 cycles after the first edge that samples en[i]=1.
- Config handshake:
  - cfg_ready = (cfg_ch < NUM_CH) && !pending[cfg_ch]. It depends only on cfg_ch and registered state.
  - A write is accepted when cfg_valid && cfg_ready. On acceptance: shadow[cfg_ch]<=cfg_div, pending<=1.
  - A write with cfg_ready=0 is ignored; it has no side effects and is not queued.
- Apply:
  - A pending value copies into div_act, and pending clears, on the channel's next terminal-count edge. That half-period ends under the old value; the new value governs the next half-period.
  - If en[i]=0, the pending value applies on the next edge regardless of cnt.
- Same-edge write and terminal count on the same channel: the terminal count uses and keeps the old div_act. The write goes to shadow and applies at the following terminal count.
- Channels are fully independent. A write to one channel never perturbs another channel's cnt or clkout.
- Zero latency from div_act to compare: the compare uses the registered div_act.

Optional Feature:
CLKDIV_TICK_EN
- Defined: adds output port tick [NUM_CH], registered, reset 0. tick[i] is high for exactly one clkin cycle, on the same edge where clkout[i] goes 0->1. It is a clock-enable for downstream logic clocked by clkin.
- Undefined: tick port and its logic are absent; everything else is identical.

Test Plan:
Bench parameters: NUM_CH=3, CNT_W=8, DEFAULT_DIV=3, CH_W=2.
1. Reset 2 cycles, then en=3'b001 -> clkout[0] rises 4 cycles after en is first sampled; period 8 cycles, 50% duty; clkout[2:1] stay 0.
2. Write ch0 div=0 while en[0]=1 -> after the current 4-cycle half-period, clkout[0] toggles every cycle; cfg_ready for ch0 is 0 from acceptance until the apply edge, then 1.
3. Write ch1 div=1 with en[1]=0, then a second ch1 write same cycle as pending -> first applies next edge; second is ignored (cfg_ready=0); enabling ch1 gives a 4-cycle period.
4. cfg_ch=3 with cfg_valid=1 -> cfg_ready=0; no channel's div_act, shadow or pending changes.
5. Assert reset while clkout[0]=1 and ch0 pending -> next edge: clkout=0, cnt=0, pending=0, div_act=3 for all channels.
6. With CLKDIV_TICK_EN, ch2 at div=3 -> tick[2] is a 1-cycle pulse every 8 cycles, coincident with clkout[2] rising; without the macro the bench compiles with no tick port.
